// File: rtl/bram_rw_seq_ctrl.sv
// ============================================================================
//  Module   : bram_rw_seq_ctrl
//  Purpose  : Write N source words to BRAM addresses 0..N-1, then read them back as a valid-flagged stream.
//             Optional macro RD_OUT_REG_EN adds a second read-output register stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rw_seq_ctrl #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [CNT_BIT-1:0] cnt_val_i,
  input  logic [DWIDTH-1:0]  wr_data_i,
  output logic               wr_req_o,
  output logic [AWIDTH-1:0]  bram_addr_o,
  output logic               bram_ce_o,
  output logic               bram_we_o,
  output logic [DWIDTH-1:0]  bram_d_o,
  input  logic [DWIDTH-1:0]  bram_q_i,
  output logic [DWIDTH-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_BIT-1:0] c_max_words = {{(CNT_BIT-1){1'b0}}, 1'b1} << AWIDTH;
  localparam logic [AWIDTH:0]    c_one       = {{AWIDTH{1'b0}}, 1'b1};
`ifdef RD_OUT_REG_EN
  localparam logic               c_drain_last = 1'b1;
`else
  localparam logic               c_drain_last = 1'b0;
`endif

  state_t              r_state, w_next_state;
  logic [AWIDTH-1:0]   r_addr, w_next_addr;
  logic [AWIDTH:0]     r_cnt, w_next_cnt, w_start_cnt;
  logic                r_drain, w_next_drain;
  logic                w_last;
  logic                r_wr_req, r_idle, r_run, r_done;
  logic                r_q_pend, r_rd_valid;
  logic [DWIDTH-1:0]   r_rd_data;

  // Counts above the address space collapse to a full pass of 2^AWIDTH words.
  assign w_start_cnt = (cnt_val_i > c_max_words) ? c_max_words[AWIDTH:0] : cnt_val_i[AWIDTH:0];
  assign w_last      = ({1'b0, r_addr} == (r_cnt - c_one));

  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    w_next_cnt   = r_cnt;
    w_next_drain = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_cnt   = w_start_cnt;
          w_next_addr  = '0;
          w_next_state = (w_start_cnt == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_next_addr  = '0;
          w_next_state = S_READ;
        end else begin
          w_next_addr = r_addr + 1'b1;
        end
      end
      S_READ: begin
        if (w_last) begin
          w_next_addr  = '0;
          w_next_state = S_DRAIN;
        end else begin
          w_next_addr = r_addr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == c_drain_last) w_next_state = S_DONE;
        else                         w_next_drain = 1'b1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_drain    <= 1'b0;
      r_wr_req   <= 1'b0;
      r_idle     <= 1'b1;
      r_run      <= 1'b0;
      r_done     <= 1'b0;
      r_q_pend   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_addr     <= w_next_addr;
      r_cnt      <= w_next_cnt;
      r_drain    <= w_next_drain;
      // Status flags are registered from the next state so they align with it.
      r_wr_req   <= (w_next_state == S_WRITE);
      r_idle     <= (w_next_state == S_IDLE);
      r_run      <= (w_next_state == S_WRITE) || (w_next_state == S_READ) ||
                    (w_next_state == S_DRAIN);
      r_done     <= (w_next_state == S_DONE);
      r_q_pend   <= (r_state == S_READ);
      r_rd_valid <= r_q_pend;
      if (r_q_pend) r_rd_data <= bram_q_i;
    end
  end

`ifdef RD_OUT_REG_EN
  logic              r_rd_valid2;
  logic [DWIDTH-1:0] r_rd_data2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid2 <= 1'b0;
      r_rd_data2  <= '0;
    end else begin
      r_rd_valid2 <= r_rd_valid;
      r_rd_data2  <= r_rd_data;
    end
  end

  assign rd_valid_o = r_rd_valid2;
  assign rd_data_o  = r_rd_data2;
`else
  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
`endif

  assign bram_ce_o   = (r_state == S_WRITE) || (r_state == S_READ);
  assign bram_we_o   = (r_state == S_WRITE);
  assign bram_addr_o = r_addr;
  assign bram_d_o    = wr_data_i;
  assign wr_req_o    = r_wr_req;
  assign idle_o      = r_idle;
  assign run_o       = r_run;
  assign done_o      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bram_rw_seq_ctrl.sv
// ============================================================================
//  Module   : tb_bram_rw_seq_ctrl
//  Purpose  : Randomized self-checking bench for bram_rw_seq_ctrl with a behavioural BRAM.
//             Honours RD_OUT_REG_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_rw_seq_ctrl;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int CB   = 31;
  localparam int MAXW = 1 << AW;
`ifdef RD_OUT_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [CB-1:0] cnt_val_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_req_o;
  logic [AW-1:0] bram_addr_o;
  logic          bram_ce_o;
  logic          bram_we_o;
  logic [DW-1:0] bram_d_o;
  logic [DW-1:0] bram_q_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          idle_o;
  logic          run_o;
  logic          done_o;

  bram_rw_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CNT_BIT(CB)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .cnt_val_i(cnt_val_i),
    .wr_data_i(wr_data_i), .wr_req_o(wr_req_o), .bram_addr_o(bram_addr_o),
    .bram_ce_o(bram_ce_o), .bram_we_o(bram_we_o), .bram_d_o(bram_d_o),
    .bram_q_i(bram_q_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .idle_o(idle_o), .run_o(run_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM, one-cycle read latency.
  logic [DW-1:0] mem [0:MAXW-1];
  always @(posedge clk) begin
    if (bram_ce_o) begin
      if (bram_we_o) mem[bram_addr_o] <= bram_d_o;
      else           bram_q_i <= mem[bram_addr_o];
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] src [0:MAXW-1];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [CB-1:0] n, input bit busy_start);
    int ne, done_cyc, first_b, last_b, nreq, widx;
    bit pop;
    int            wr_addr[$];
    logic [DW-1:0] wr_dat[$];
    int            rd_addr[$];
    logic [DW-1:0] beats[$];
    ne = (n > CB'(MAXW)) ? MAXW : int'(n);
    for (int i = 0; i < MAXW; i++) src[i] = $urandom;
    widx      = 0;
    wr_data_i = src[0];
    cnt_val_i = n;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
    cnt_val_i = CB'($urandom);
    done_cyc = -1; first_b = -1; last_b = -1; nreq = 0;
    for (int cyc = 1; cyc <= 2 * MAXW + 8 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      pop = wr_req_o;
      if (wr_req_o) nreq++;
      if (bram_ce_o && bram_we_o) begin
        wr_addr.push_back(int'(bram_addr_o));
        wr_dat.push_back(bram_d_o);
      end
      if (bram_ce_o && !bram_we_o) rd_addr.push_back(int'(bram_addr_o));
      if (rd_valid_o) begin
        beats.push_back(rd_data_o);
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
      end
      if (done_o) begin
        done_cyc = cyc;
        check("done_run", longint'(run_o), 0);
        check("done_idle", longint'(idle_o), 0);
      end
      if (busy_start && cyc == 2) begin
        start_i   = 1'b1;
        cnt_val_i = CB'(3);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (pop) widx++;
      wr_data_i = src[widx % MAXW];
    end
    @(negedge clk);
    check("post_idle", longint'(idle_o), 1);
    check("post_done", longint'(done_o), 0);
    check("done_cyc", done_cyc, (ne == 0) ? 1 : 2 * ne + 2 + XL);
    check("n_writes", wr_addr.size(), ne);
    check("n_req", nreq, ne);
    check("n_reads", rd_addr.size(), ne);
    check("n_beats", beats.size(), ne);
    for (int i = 0; i < ne && i < wr_addr.size(); i++) begin
      check("wr_addr", wr_addr[i], i);
      check("wr_data", longint'(wr_dat[i]), longint'(src[i]));
    end
    for (int i = 0; i < ne && i < rd_addr.size(); i++) check("rd_addr", rd_addr[i], i);
    for (int i = 0; i < ne && i < beats.size(); i++)
      check("rd_data", longint'(beats[i]), longint'(src[i]));
    if (ne > 0) begin
      check("first_beat", first_b, ne + 3 + XL);
      check("last_beat", last_b, done_cyc);
      check("beat_span", last_b - first_b + 1, ne);
    end
  endtask

  task automatic mid_reset();
    int ndone;
    for (int i = 0; i < MAXW; i++) src[i] = $urandom;
    wr_data_i = src[0];
    cnt_val_i = CB'(6);
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("in_read", longint'(bram_ce_o && !bram_we_o), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", longint'(idle_o), 1);
    check("rst_run", longint'(run_o), 0);
    check("rst_valid", longint'(rd_valid_o), 0);
    check("rst_ce", longint'(bram_ce_o), 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o || rd_valid_o) ndone++;
    end
    check("rst_no_done", ndone, 0);
  endtask

  initial begin
    logic [CB-1:0] n;
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CB-1:0] n;
    reset = 1'b1; start_i = 1'b0; cnt_val_i = '0; wr_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_idle", longint'(idle_o), 1);
    #1 reset = 1'b0;
    @(negedge clk);
    check("init_idle", longint'(idle_o), 1);
    check("init_run", longint'(run_o), 0);
    check("init_done", longint'(done_o), 0);
    check("init_ce", longint'(bram_ce_o), 0);
    check("init_we", longint'(bram_we_o), 0);
    check("init_valid", longint'(rd_valid_o), 0);
    check("init_req", longint'(wr_req_o), 0);
    check("init_addr", longint'(bram_addr_o), 0);
    @(posedge clk); #1;
    run_seq(CB'(4), 1'b0);
    run_seq(CB'(0), 1'b0);
    run_seq(CB'(300), 1'b0);
    run_seq(CB'(5), 1'b1);
    mid_reset();
    run_seq(CB'(2), 1'b0);
    run_seq(CB'(1), 1'b1);
    run_seq(CB'(256), 1'b0);
    run_seq(CB'(257), 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) n = CB'($urandom);
      else            n = CB'($urandom_range(0, 20));
      run_seq(n, k[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_rw_seq_ctrl.md
Name: bram_rw_seq_ctrl

Overview:
Sequencer for a single-port BRAM shared by one write pass and one read pass. On start it writes N words from an upstream source into addresses 0..N-1, then reads the same N addresses back and streams them out with a valid flag. It exposes idle/run/done status and sits between the host control logic and the BRAM.

Parameters:
AWIDTH, 8, BRAM address width; maximum pass length is 2^AWIDTH words
DWIDTH, 32, BRAM data width
CNT_BIT, 31, width of the requested word count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_i  input  1  start pulse; sampled only in IDLE
cnt_val_i  input  CNT_BIT  number of words N; latched on accepted start
wr_data_i  input  DWIDTH  write source data; valid whenever wr_req_o=1
wr_req_o  output  1  source pop; one word consumed per cycle when high
bram_addr_o  output  AWIDTH  BRAM address
bram_ce_o  output  1  BRAM chip enable
bram_we_o  output  1  BRAM write enable
bram_d_o  output  DWIDTH  BRAM write data (= wr_data_i)
bram_q_i  input  DWIDTH  BRAM read data; 1-cycle latency after ce with we=0
rd_data_o  output  DWIDTH  read-back data
rd_valid_o  output  1  rd_data_o valid
idle_o  output  1  high in IDLE
run_o  output  1  high in WRITE, READ or DRAIN
done_o  output  1  one-cycle pulse at end of sequence

Behaviour:
- One clock; reset is synchronous and active-high.
- While reset is high, or on the next edge after reset is released: state=IDLE, address counter=0, latched count=0. All outputs are 0 except idle_o=1.
- Reset asserted mid-operation aborts the sequence on that edge. No done_o pulse is produced.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE with start_i=1: latch N.
  - N is clamped to 2^AWIDTH if cnt_val_i > 2^AWIDTH. Store N in AWIDTH+1 bits.
  - If N=0, go to DONE. Otherwise go to WRITE with addr=0.
- In states other than IDLE, start_i is ignored (no queueing).
- WRITE: ce=1, we=1, wr_req_o=1, bram_d_o=wr_data_i, addr increments each cycle.
  - Lasts exactly N cycles, covering addresses 0..N-1.
  - After address N-1: addr returns to 0 and the state goes to READ.
- READ: ce=1, we=0, addr 0..N-1, one per cycle. After address N-1 the state goes to DRAIN.
- DRAIN: one cycle with ce=0. The last read word is returned in this cycle. Then go to DONE.
- rd_valid_o / rd_data_o are registered from bram_q_i, one cycle after each READ address cycle.
  - Exactly N valid beats, contiguous, in address order.
  - The first beat arrives 2 cycles after the first READ cycle. The last beat is in DONE.
- DONE: done_o=1 for one cycle; run_o=0; idle_o=0. Next state is IDLE.
- Total latency from the start edge to the done_o cycle is 2N+2 cycles for N>0, and 1 cycle for N=0.
- Address counter wraps naturally only at N=2^AWIDTH: the last address is all-ones, after which it returns to 0.
- bram_ce_o/bram_we_o are combinational from state. All other outputs are registered or driven directly from the address register.

Optional Feature:
Macro RD_OUT_REG_EN.
- Defined: adds a second output register stage on rd_data_o/rd_valid_o. All N beats shift one cycle later. DRAIN lasts 2 cycles, so done_o still coincides with the last valid beat. Total latency is 2N+3 for N>0.
- Undefined: single registered stage, as described in Behaviour.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> idle_o=1, run_o=0, done_o=0, ce/we=0, rd_valid_o=0.
- Basic sequence: start with N=4, source supplies 0xA0..0xA3 -> writes go to addr 0..3 with we=1; then read addr 0..3; rd_valid_o high 4 contiguous cycles with data 0xA0..0xA3; done_o pulses at cycle 10 after start.
- Zero length: N=0 -> no ce/we/wr_req_o activity; done_o pulses the cycle after start; back to IDLE.
- Clamp/wrap with AWIDTH=8: N=300 -> exactly 256 writes (addr 0..255) and 256 valid read beats; addr returns to 0 between passes.
- Start while busy plus mid-run reset: pulse start_i during WRITE -> ignored; then assert reset during READ -> next cycle idle_o=1, no done_o, rd_valid_o=0; a fresh start with N=2 completes normally.
- With RD_OUT_REG_EN defined: N=4 -> valid beats shifted by 1 cycle, done_o at cycle 11, coinciding with the last beat.
